// File: rtl/pc_gen_unit_if.sv
// Decode/WB <-> fetch PC generator bundle: control-flow operands in, SRAM address and link write out.
// Purely wiring; all timing lives in pc_gen_unit.
interface pc_gen_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              br_valid;
  logic [3:0]        br_type;
  logic [ADDR_W-1:0] inst_pc;
  logic [15:0]       b_offset;
  logic [25:0]       j_index;
  logic [31:0]       rdata1;
  logic [31:0]       rdata2;
  logic              exc_req;
  logic              eret_req;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] current_pc;
  logic              inst_sram_en;
  logic              redirect;
  logic              pending;
  logic              link_wen;
  logic [ADDR_W-1:0] link_addr;
  logic              addr_err;

  modport master (
    output stall, br_valid, br_type, inst_pc, b_offset, j_index, rdata1, rdata2,
           exc_req, eret_req, epc,
    input  next_pc, current_pc, inst_sram_en, redirect, pending, link_wen, link_addr, addr_err
  );

  modport slave (
    input  stall, br_valid, br_type, inst_pc, b_offset, j_index, rdata1, rdata2,
           exc_req, eret_req, epc,
    output next_pc, current_pc, inst_sram_en, redirect, pending, link_wen, link_addr, addr_err
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: resolves branches/jumps, exception/ERET redirects; next_pc is combinational,
// current_pc follows one edge later. A taken target seen under stall is parked until stall drops.
module pc_gen_unit #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 'hbfc00000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 'hbfc00380
) (
  input  logic        clk,
  input  logic        resetn,
  pc_gen_unit_if.slave bus
);
  typedef enum logic {IDLE, PENDING} state_e;

  localparam logic [ADDR_W-1:0] FOUR  = 4;
  localparam logic [ADDR_W-1:0] EIGHT = 8;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q;
  logic              redirect_q;

  logic              cond, is_link, idle, taken_now, pend_load, take_load, override_req, redir_sel;
  logic              rs_neg, rs_zero;
  logic [ADDR_W-1:0] pc4, br_tgt, j_tgt, tgt;

  assign rs_neg  = bus.rdata1[31];
  assign rs_zero = (bus.rdata1 == 32'd0);
  assign pc4     = bus.inst_pc + FOUR;
  assign br_tgt  = pc4 + {{(ADDR_W-18){bus.b_offset[15]}}, bus.b_offset, 2'b00};
  assign j_tgt   = {pc4[ADDR_W-1:28], bus.j_index, 2'b00};

  always_comb begin
    cond    = 1'b0;
    is_link = 1'b0;
    tgt     = br_tgt;
    case (bus.br_type)
      4'h0: cond = (bus.rdata1 != bus.rdata2);
      4'h1: cond = (bus.rdata1 == bus.rdata2);
      4'h2: cond = ~rs_neg;
      4'h3: cond = ~rs_neg & ~rs_zero;
      4'h4: cond = rs_neg | rs_zero;
      4'h5: cond = rs_neg;
      4'h6: begin cond = ~rs_neg; is_link = 1'b1; end
      4'h7: begin cond = rs_neg;  is_link = 1'b1; end
      4'h8: begin cond = 1'b1; tgt = j_tgt; end
      4'h9: begin cond = 1'b1; tgt = j_tgt; is_link = 1'b1; end
      4'hA: begin cond = 1'b1; tgt = bus.rdata1[ADDR_W-1:0]; end
      4'hB: begin cond = 1'b1; tgt = bus.rdata1[ADDR_W-1:0]; is_link = 1'b1; end
      default: ;
    endcase
  end

  assign idle         = (state_q == IDLE);
  assign taken_now    = bus.br_valid & cond & idle;
  assign override_req = bus.exc_req | bus.eret_req;
  assign pend_load    = ~idle & ~bus.stall;
  assign take_load    = taken_now & ~bus.stall;
  assign redir_sel    = resetn & (override_req | pend_load | take_load);

  always_comb begin
    if (!resetn)           pc_d = RESET_VECTOR;
    else if (bus.exc_req)  pc_d = EXC_VECTOR;
    else if (bus.eret_req) pc_d = bus.epc;
    else if (pend_load)    pc_d = tgt_q;
    else if (take_load)    pc_d = tgt;
    else if (bus.stall)    pc_d = pc_q;
    else                   pc_d = pc_q + FOUR;
  end

  // Redirects dominate: an exception or ERET drops both a parked and a fresh target.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redir_sel;
      if (override_req) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (taken_now && bus.stall) begin
            tgt_q   <= tgt;
            state_q <= PENDING;
          end
          PENDING: if (!bus.stall) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.next_pc      = pc_d;
  assign bus.current_pc   = pc_q;
  assign bus.redirect     = redirect_q;
  assign bus.pending      = (state_q == PENDING);
  assign bus.inst_sram_en = ~resetn | ~bus.stall | override_req;
  assign bus.link_wen     = bus.br_valid & is_link & idle;
  assign bus.link_addr    = bus.inst_pc + EIGHT;
  assign bus.addr_err     = resetn & ~override_req &
                            ((pend_load & (tgt_q[1:0] != 2'b00)) |
                             (taken_now & (tgt[1:0] != 2'b00)));
endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Next-generation fetch PC generator for the 5-stage MIPS core.
- Resolves every control-flow instruction class: BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, BGEZAL, BLTZAL, J, JAL, JR and JALR.
- Adds exception and ERET redirects, and a pending-redirect register so a branch resolved during a stall is neither lost nor re-evaluated.
- Sits between decode/register read and the instruction SRAM. Drives the SRAM address and the link-address write for the regfile.

Parameters:
- ADDR_W, 32, PC width; must be ≥ 28 + 2.
- RESET_VECTOR, 32'hbfc00000, PC loaded during reset.
- EXC_VECTOR, 32'hbfc00380, exception entry PC.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  synchronous active-low reset
- stall  in  1  pipeline stall; hold fetch PC
- br_valid  in  1  decode holds a control-flow instruction
- br_type  in  4  control-flow kind (encoding below)
- inst_pc  in  ADDR_W  PC of the control-flow instruction in decode
- b_offset  in  16  branch immediate
- j_index  in  26  jump index
- rdata1  in  32  rs value
- rdata2  in  32  rt value
- exc_req  in  1  exception redirect request (from WB)
- eret_req  in  1  ERET redirect request
- epc  in  ADDR_W  ERET target
- next_pc  out  ADDR_W  PC to be loaded at the next edge; also the SRAM address
- current_pc  out  ADDR_W  registered fetch PC
- inst_sram_en  out  1  SRAM read enable
- redirect  out  1  registered; high for one cycle after a non-sequential PC load
- pending  out  1  a taken target is latched, awaiting stall release
- link_wen  out  1  combinational; write link_addr to r31 (or rd for JALR)
- link_addr  out  ADDR_W  inst_pc + 8
- addr_err  out  1  combinational; selected target has bits[1:0] ≠ 0

Behaviour:
- br_type encoding: 0 BNE, 1 BEQ, 2 BGEZ, 3 BGTZ, 4 BLEZ, 5 BLTZ, 6 BGEZAL, 7 BLTZAL, 8 J, 9 JAL, A JR, B JALR. Codes C–F: never taken, link_wen 0.
- Conditions:
  - BEQ/BNE compare rdata1 against rdata2.
  - The remaining branch conditions use signed rdata1 vs 0.
  - Jumps are always taken.
- Targets:
  - Branches: inst_pc + 4 + (sext(b_offset) << 2), mod 2^ADDR_W.
  - J/JAL: {(inst_pc+4)[ADDR_W-1:28], j_index, 2'b00}.
  - JR/JALR: rdata1[ADDR_W-1:0].
- link_wen = br_valid & type ∈ {6, 7, 9, B}. link_wen asserts regardless of the condition, and only when state is IDLE.
- taken_now = br_valid & condition & state == IDLE.
- FSM states:
  - IDLE:
    - taken_now & stall → latch target, go to PENDING.
    - taken_now & ~stall → load the target directly.
  - PENDING:
    - br_valid is ignored.
    - On ~stall, load the latched target and return to IDLE.
    - pending = (state == PENDING).
- next_pc priority, highest first:
  1. ~resetn → RESET_VECTOR
  2. exc_req → EXC_VECTOR
  3. eret_req → epc
  4. PENDING & ~stall → latched target
  5. taken_now & ~stall → computed target
  6. stall → current_pc
  7. otherwise → current_pc + 4
- Override and register updates:
  - exc_req or eret_req overrides stall, clears PENDING to IDLE, and discards any taken_now.
  - current_pc <= next_pc every edge.
  - redirect <= resetn & (priority 2–5 selected).
- addr_err reflects the target that is loaded or latched. The PC still loads; exception logic decides.
- inst_sram_en = ~resetn | ~stall | exc_req | eret_req.
- Reset values:
  - current_pc = RESET_VECTOR, state IDLE, latched target 0, redirect 0, pending 0.
  - Reset mid-PENDING discards the latched target.
- Latency: a taken branch in decode with no stall gives current_pc = target one edge later. Stall release in PENDING gives target one edge after stall falls.

Test Plan:
- Reset held 2 cycles, release → current_pc 0xbfc00000, then 0xbfc00004, 0xbfc00008; redirect 0.
- BEQ at inst_pc 0xbfc00010, offset 0x0003, rdata1 = rdata2 = 5, no stall → next edge current_pc 0xbfc00020, redirect 1 for one cycle. Same with rdata2 = 6 → sequential.
- BLTZAL, rdata1 = 0x80000000, stall high 3 cycles → pending 1, current_pc held; stall low → current_pc = target; link_wen 1 in first IDLE cycle only; link_addr = inst_pc + 8.
- JR with rdata1 0x00400002 → addr_err 1, current_pc 0x00400002.
- PENDING with exc_req & stall → current_pc 0xbfc00380, pending 0, latched target never loaded.
- ERET with epc 0x00401000 while a BNE is taken → current_pc 0x00401000; the branch is discarded.
